// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field positions and the register-index type.
// Decoded by regfile_scoreboard and its rf_scoreboard sub-module.
package cpu_pkg;

    localparam int INSTR_W   = 32;
    localparam int DEST_MSB  = 28;
    localparam int SRCA_MSB  = 24;
    localparam int SRCB_MSB  = 20;
    localparam int RF_ADDR_W = 4;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    // Full-width index field whose MSB sits at instr[msb]; narrower register
    // files take the upper bits of this so the field stays MSB-anchored.
    function automatic reg_idx_t field_idx(input logic [INSTR_W-1:0] instr, input int msb);
        return reg_idx_t'(instr >> (msb - RF_ADDR_W + 1));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: RAW/WAW hazard detection, busy set/clear and sticky wb_err.
// Optional macro RF_BYPASS_EN lets a same-cycle write-back mask the busy bit it clears.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_wr_en,
    input  logic [ADDR_W-1:0]     dest,
    input  logic [ADDR_W-1:0]     src_a,
    input  logic [ADDR_W-1:0]     src_b,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    output logic                  issue_ready,
    output logic [2**ADDR_W-1:0]  busy_vec,
    output logic                  wb_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] busy_eff;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic             wb_err_reg;
    logic             wb_live;
    logic             hazard;
    logic             accept;

    // Write-backs to the hardwired zero register are dropped entirely.
    assign wb_live = wb_valid & ~((ZERO_REG != 0) && (wb_addr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
            assign set_vec[gi]   = !IS_ZERO && accept && issue_wr_en && (dest == ADDR_W'(gi));
            assign clr_vec[gi]   = wb_live && (wb_addr == ADDR_W'(gi));
            // A new issue claiming the register outranks the retiring write-back.
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
`ifdef RF_BYPASS_EN
            assign busy_eff[gi]  = busy_reg[gi] & ~clr_vec[gi];
`else
            assign busy_eff[gi]  = busy_reg[gi];
`endif
        end
    endgenerate

    assign hazard      = busy_eff[src_a] | busy_eff[src_b] | (issue_wr_en & busy_eff[dest]);
    assign issue_ready = ~hazard;
    assign accept      = issue_valid & issue_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_reg   <= '0;
            wb_err_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            if (wb_live && !busy_reg[wb_addr]) begin
                wb_err_reg <= 1'b1;
            end
        end
    end

    assign busy_vec = busy_reg;
    assign wb_err   = wb_err_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with busy scoreboard, optional zero register and stall counter.
// Optional macro RF_BYPASS_EN forwards write-back data to the read ports in the same cycle.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  issue_valid,
    input  logic                  issue_wr_en,
    output logic                  issue_ready,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [2**ADDR_W-1:0]  busy_vec,
    output logic                  wb_err,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int DEPTH = 2**ADDR_W;

    reg_idx_t          dest_full;
    reg_idx_t          src_a_full;
    reg_idx_t          src_b_full;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src_vec [2];
    logic [DATA_W-1:0] rd_vec  [2];
    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [CNT_W-1:0]  stall_count_reg;

    assign dest_full  = field_idx(instr, DEST_MSB);
    assign src_a_full = field_idx(instr, SRCA_MSB);
    assign src_b_full = field_idx(instr, SRCB_MSB);
    assign dest       = dest_full[RF_ADDR_W-1 -: ADDR_W];
    assign src_vec[0] = src_a_full[RF_ADDR_W-1 -: ADDR_W];
    assign src_vec[1] = src_b_full[RF_ADDR_W-1 -: ADDR_W];

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wr_en (issue_wr_en),
        .dest        (dest),
        .src_a       (src_vec[0]),
        .src_b       (src_vec[1]),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .issue_ready (issue_ready),
        .busy_vec    (busy_vec),
        .wb_err      (wb_err)
    );

    genvar gi;
    generate
        // Each entry resets to zero, so storage is flops rather than block RAM.
        for (gi = 0; gi < DEPTH; gi++) begin : g_regs
            localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    regs_reg[gi] <= '0;
                end else if (!IS_ZERO && wb_valid && (wb_addr == ADDR_W'(gi))) begin
                    regs_reg[gi] <= wb_data;
                end
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_vec[gi] = regs_reg[src_vec[gi]];
`ifdef RF_BYPASS_EN
                if (wb_valid && (wb_addr == src_vec[gi])) begin
                    rd_vec[gi] = wb_data;
                end
`endif
                if ((ZERO_REG != 0) && (src_vec[gi] == '0)) begin
                    rd_vec[gi] = '0;
                end
            end
        end
    endgenerate

    assign rd_data_a = rd_vec[0];
    assign rd_data_b = rd_vec[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if (issue_valid && !issue_ready && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- Decodes register indices from the 32-bit instruction word and provides two combinational read ports and one write-back port.
- Adds a per-register busy scoreboard that stalls issue on RAW/WAW hazards, an optional hardwired zero register, and a saturating stall counter.
- Sits between decode/issue and the execute/write-back stages of the CPU.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, index width; DEPTH = 2**ADDR_W; legal range 1..4.
- ZERO_REG, 1, if 1, register 0 always reads 0, ignores writes and is never busy.
- CNT_W, 16, width of stall_count.

Ports:
- clock  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr  input  32  instruction word: dest = instr[28-:ADDR_W], src_a = instr[24-:ADDR_W], src_b = instr[20-:ADDR_W].
- issue_valid  input  1  decode presents an instruction.
- issue_wr_en  input  1  instruction will write dest.
- issue_ready  output  1  instruction accepted this cycle if issue_valid.
- rd_data_a  output  DATA_W  value of src_a.
- rd_data_b  output  DATA_W  value of src_b.
- wb_valid  input  1  write-back strobe.
- wb_addr  input  ADDR_W  write-back register index.
- wb_data  input  DATA_W  write-back data.
- busy_vec  output  DEPTH  scoreboard bits, bit i = register i pending.
- wb_err  output  1  sticky: write-back to a non-busy register.
- stall_count  output  CNT_W  cycles with issue_valid=1 and issue_ready=0.

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, busy_vec 0, wb_err 0, stall_count 0. issue_ready and read ports follow combinationally from the cleared state.
- Reads are combinational: rd_data_x = regs[src_x]. If ZERO_REG=1 and src_x=0, the read returns 0.
- hazard = busy[src_a] | busy[src_b] | (issue_wr_en & busy[dest]).
- issue_ready = ~hazard. It is independent of issue_valid.
- Accept = issue_valid & issue_ready. On accept with issue_wr_en=1 and dest is not the zero register, busy[dest] <= 1 at the next edge.
- Write-back (wb_valid=1): regs[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - If ZERO_REG=1 and wb_addr=0: no write, no busy change, no error.
  - If busy[wb_addr]=0 before the edge: the write still occurs and wb_err <= 1. wb_err clears only on reset.
- Same-cycle accept setting busy[k] and write-back clearing busy[k]: set wins, busy[k] stays 1. Without RF_BYPASS_EN this requires busy[k]=0, so wb_err also sets.
- stall_count increments on each cycle with issue_valid=1 and issue_ready=0, and saturates at 2**CNT_W-1.
- Latency: write-back data is visible on read ports the cycle after the write edge. busy clears at the same edge.
- Reset asserted mid-stall clears the scoreboard, so issue_ready rises immediately.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - While wb_valid=1 and wb_addr=src_x (src_x not the zero register), rd_data_x = wb_data in the same cycle.
  - busy[wb_addr] is treated as 0 in the hazard equation for that cycle, so a dependent instruction issues in the write-back cycle.
- Undefined: no forwarding. Dependents wait one extra cycle; issue_ready rises the cycle after write-back.

Decomposition:
- Shared package cpu_pkg holds:
  - field MSB constants DEST_MSB=28, SRCA_MSB=24, SRCB_MSB=20;
  - INSTR_W=32;
  - a typedef for the register index derived from ADDR_W.
- One sub-module, rf_scoreboard: busy bits, hazard logic and wb_err. The storage array and read/bypass muxes stay in the top.

Test Plan:
- Reset: after reset deasserts, reads of every index return 0, busy_vec=0, issue_ready=1, stall_count=0.
- Write/read: wb to r5 with 0xBEEF while not busy -> r5 reads 0xBEEF next cycle, wb_err=1. Reset -> wb_err=0.
- RAW stall:
  - issue dest=r3 with wr_en -> busy_vec[3]=1;
  - next instruction with src_a=r3 -> issue_ready=0 and stall_count counts 2 over 2 cycles;
  - wb r3=0x1234 -> issue_ready=1 next cycle (same cycle with RF_BYPASS_EN, rd_data_a=0x1234).
- WAW: r7 busy; issue dest=r7 with wr_en=1 -> stall. Same instruction with wr_en=0 and sources not r7 -> accepted.
- Zero register (ZERO_REG=1):
  - wb r0=0xFFFF -> r0 reads 0, no wb_err;
  - issue dest=r0 -> busy_vec[0] stays 0.
- Simultaneous set/clear:
  - with RF_BYPASS_EN, r2 busy, wb r2 and accept dest=r2 same cycle -> busy_vec[2]=1, r2 holds the wb data;
  - stall_count with CNT_W=4 saturates at 15.
